// File: rtl/anabellek_hakem_if.sv
// Bundle of the instruction-cache, data-cache and main-memory iomem signals seen by the
// arbiter. The slave modport is the arbiter's view; the master modport is its surroundings.
interface anabellek_hakem_if;
  logic [18:2] l1b_addr_i;
  logic        l1b_valid_i;
  logic [31:0] l1b_rdata_o;
  logic        l1b_ready_o;

  logic [18:2] l1v_addr_i;
  logic        l1v_valid_i;
  logic [31:0] l1v_wdata_i;
  logic [3:0]  l1v_wstrb_i;
  logic [31:0] l1v_rdata_o;
  logic        l1v_ready_o;

  logic [18:2] iomem_addr_o;
  logic        iomem_valid_o;
  logic [31:0] iomem_wdata_o;
  logic [3:0]  iomem_wstrb_o;
  logic [31:0] iomem_rdata_i;
  logic        iomem_ready_i;

  modport slave (
    input  l1b_addr_i, l1b_valid_i,
    output l1b_rdata_o, l1b_ready_o,
    input  l1v_addr_i, l1v_valid_i, l1v_wdata_i, l1v_wstrb_i,
    output l1v_rdata_o, l1v_ready_o,
    output iomem_addr_o, iomem_valid_o, iomem_wdata_o, iomem_wstrb_o,
    input  iomem_rdata_i, iomem_ready_i
  );

  modport master (
    output l1b_addr_i, l1b_valid_i,
    input  l1b_rdata_o, l1b_ready_o,
    output l1v_addr_i, l1v_valid_i, l1v_wdata_i, l1v_wstrb_i,
    input  l1v_rdata_o, l1v_ready_o,
    input  iomem_addr_o, iomem_valid_o, iomem_wdata_o, iomem_wstrb_o,
    output iomem_rdata_i, iomem_ready_i
  );
endinterface

// File: rtl/anabellek_hakem.sv
// Round-robin main-memory arbiter between the L1 instruction and data cache controllers,
// with a watchdog that force-completes transactions the memory never acknowledges.
module anabellek_hakem #(
  parameter int unsigned ZAMAN_ASIMI = 1024,
  parameter logic [31:0] HATA_VERISI = 32'hDEAD_BEEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  anabellek_hakem_if.slave         bus,
  output logic                     hata_o
);

  localparam int unsigned CntW = (ZAMAN_ASIMI > 2) ? $clog2(ZAMAN_ASIMI) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'((ZAMAN_ASIMI == 0) ? 0 : ZAMAN_ASIMI - 1);

  typedef enum logic [1:0] {
    StBosta,
    StL1bAktif,
    StL1vAktif
  } state_e;

  state_e          state_q, state_d;
  logic            son_sahip_q, son_sahip_d;  // 1: L1V won the last grant
  logic [CntW-1:0] sayac_q, sayac_d;
  logic            hata_q, hata_d;
  logic            aktif;
  logic            zaman_doldu;
  logic            bitti;

  assign aktif = (state_q == StL1bAktif) || (state_q == StL1vAktif);
  assign zaman_doldu = (ZAMAN_ASIMI != 0) && aktif && !bus.iomem_ready_i && (sayac_q == CntMax);
  assign bitti = aktif && (bus.iomem_ready_i || zaman_doldu);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StBosta;
      son_sahip_q <= 1'b1;
      sayac_q     <= '0;
      hata_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      son_sahip_q <= son_sahip_d;
      sayac_q     <= sayac_d;
      hata_q      <= hata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    son_sahip_d = son_sahip_q;
    sayac_d     = sayac_q;
    hata_d      = hata_q;
    unique case (state_q)
      StBosta: begin
        sayac_d = '0;
        // On a tie the port that did not win last time gets the bus.
        if (bus.l1b_valid_i && (!bus.l1v_valid_i || son_sahip_q)) begin
          state_d     = StL1bAktif;
          son_sahip_d = 1'b0;
        end else if (bus.l1v_valid_i) begin
          state_d     = StL1vAktif;
          son_sahip_d = 1'b1;
        end
      end
      StL1bAktif, StL1vAktif: begin
        if (bitti) begin
          state_d = StBosta;
          hata_d  = hata_q | zaman_doldu;
        end else begin
          sayac_d = sayac_q + CntW'(1);
        end
      end
      default: state_d = StBosta;
    endcase
  end

  always_comb begin
    bus.iomem_valid_o = 1'b0;
    bus.iomem_addr_o  = '0;
    bus.iomem_wdata_o = '0;
    bus.iomem_wstrb_o = '0;
    bus.l1b_ready_o   = 1'b0;
    bus.l1v_ready_o   = 1'b0;
    bus.l1b_rdata_o   = bus.iomem_rdata_i;
    bus.l1v_rdata_o   = bus.iomem_rdata_i;
    unique case (state_q)
      StL1bAktif: begin
        bus.iomem_valid_o = 1'b1;
        bus.iomem_addr_o  = bus.l1b_addr_i;
        bus.l1b_ready_o   = bitti;
        if (zaman_doldu) bus.l1b_rdata_o = HATA_VERISI;
      end
      StL1vAktif: begin
        bus.iomem_valid_o = 1'b1;
        bus.iomem_addr_o  = bus.l1v_addr_i;
        bus.iomem_wdata_o = bus.l1v_wdata_i;
        bus.iomem_wstrb_o = bus.l1v_wstrb_i;
        bus.l1v_ready_o   = bitti;
        if (zaman_doldu) bus.l1v_rdata_o = HATA_VERISI;
      end
      default: ;
    endcase
  end

  assign hata_o = hata_q;

endmodule

// File: tb/tb_anabellek_hakem.sv
// Randomized bench for anabellek_hakem: a transaction-level reference model queues the
// expected bus grants and responses, and an independent monitor checks them.
module tb_anabellek_hakem;
  localparam int unsigned Z = 8;
  localparam logic [31:0] Hata = 32'hDEAD_BEEF;

  typedef struct {
    int          port;
    logic [18:2] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_t;

  typedef struct {
    int          port;
    logic [31:0] rdata;
  } resp_t;

  logic clk_i = 1'b0;
  logic rst_i;
  logic hata_o;
  anabellek_hakem_if dif();

  anabellek_hakem #(
    .ZAMAN_ASIMI(Z),
    .HATA_VERISI(Hata)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (dif),
    .hata_o(hata_o)
  );

  always #5 clk_i = ~clk_i;

  bus_t  bus_q[$];
  resp_t resp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  bit    checking = 1'b0;

  // Reference model state: who owns the bus, who won last, cycles waited, sticky error.
  int m_owner = 0;
  int m_last = 2;
  int m_wait = 0;
  bit m_hata = 1'b0;
  bit exp_busy_cur = 1'b0;
  bit exp_hata_cur = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: evaluates each cycle from the inputs alone.
  initial begin
    bus_t  b;
    resp_t r;
    int    win;
    forever begin
      @(negedge clk_i);
      exp_busy_cur = (m_owner != 0);
      exp_hata_cur = m_hata;
      if (m_owner != 0) begin
        if (dif.iomem_ready_i) begin
          r.port = m_owner; r.rdata = dif.iomem_rdata_i;
          resp_q.push_back(r);
          m_owner = 0;
        end else if (m_wait == int'(Z) - 1) begin
          r.port = m_owner; r.rdata = Hata;
          resp_q.push_back(r);
          m_hata  = 1'b1;
          m_owner = 0;
        end else begin
          m_wait++;
        end
      end else if (!rst_i) begin
        win = 0;
        if (dif.l1b_valid_i && dif.l1v_valid_i) win = (m_last == 1) ? 2 : 1;
        else if (dif.l1b_valid_i) win = 1;
        else if (dif.l1v_valid_i) win = 2;
        if (win == 1) begin
          b.port = 1; b.addr = dif.l1b_addr_i; b.wdata = '0; b.wstrb = '0;
        end else begin
          b.port = 2; b.addr = dif.l1v_addr_i; b.wdata = dif.l1v_wdata_i;
          b.wstrb = dif.l1v_wstrb_i;
        end
        if (win != 0) begin
          bus_q.push_back(b);
          m_owner = win;
          m_last  = win;
          m_wait  = 0;
        end
      end
      if (rst_i) begin
        m_owner = 0; m_last = 2; m_wait = 0; m_hata = 1'b0;
      end
    end
  end

  // Monitor: compares DUT outputs against the queued expectations.
  initial begin
    bit    prev_valid = 1'b0;
    bus_t  b;
    resp_t r;
    int    act_port;
    forever begin
      @(negedge clk_i);
      #2;
      if (checking) begin
        check("iomem_valid", dif.iomem_valid_o, exp_busy_cur);
        check("hata", hata_o, exp_hata_cur);
        if (dif.iomem_valid_o === 1'b1 && !prev_valid) begin
          check("grant_queued", bus_q.size(), 1);
          if (bus_q.size() != 0) begin
            b = bus_q.pop_front();
            check("iomem_addr", 32'(dif.iomem_addr_o), 32'(b.addr));
            check("iomem_wdata", dif.iomem_wdata_o, b.wdata);
            check("iomem_wstrb", 32'(dif.iomem_wstrb_o), 32'(b.wstrb));
          end
        end
        if (dif.iomem_valid_o === 1'b0) begin
          check("idle_addr", 32'(dif.iomem_addr_o), 0);
          check("idle_wstrb", 32'(dif.iomem_wstrb_o), 0);
        end
        if (dif.l1b_ready_o === 1'b1 || dif.l1v_ready_o === 1'b1) begin
          check("ready_onehot", 32'(dif.l1b_ready_o & dif.l1v_ready_o), 0);
          check("resp_queued", resp_q.size(), 1);
          if (resp_q.size() != 0) begin
            r = resp_q.pop_front();
            act_port = dif.l1b_ready_o ? 1 : 2;
            check("ready_port", act_port, r.port);
            check("rdata", (act_port == 1) ? dif.l1b_rdata_o : dif.l1v_rdata_o, r.rdata);
          end
        end else begin
          check("ready_missing", resp_q.size(), 0);
        end
        resp_q.delete();
        prev_valid = (dif.iomem_valid_o === 1'b1);
      end
    end
  end

  initial begin
    bit bd, vd, drained;
    rst_i = 1'b1;
    dif.l1b_valid_i = 1'b0; dif.l1b_addr_i = '0;
    dif.l1v_valid_i = 1'b0; dif.l1v_addr_i = '0; dif.l1v_wdata_i = '0; dif.l1v_wstrb_i = '0;
    dif.iomem_ready_i = 1'b0; dif.iomem_rdata_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    checking = 1'b1;
    // Tie right after reset: L1B read of 0x00040 against an L1V write-back to 0x1FF00.
    dif.l1b_valid_i = 1'b1; dif.l1b_addr_i = 17'h00010;
    dif.l1v_valid_i = 1'b1; dif.l1v_addr_i = 17'h07FC0;
    dif.l1v_wdata_i = 32'hCAFE_F00D; dif.l1v_wstrb_i = 4'hF;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      bd = dif.l1b_ready_o; vd = dif.l1v_ready_o;
      @(posedge clk_i);
      #1;
      if (bd || !dif.l1b_valid_i) begin
        dif.l1b_valid_i = ($urandom_range(0, 3) != 0);
        dif.l1b_addr_i  = 17'($urandom);
      end
      if (vd || !dif.l1v_valid_i) begin
        dif.l1v_valid_i = ($urandom_range(0, 3) != 0);
        dif.l1v_addr_i  = 17'($urandom);
        dif.l1v_wdata_i = $urandom;
        dif.l1v_wstrb_i = $urandom_range(0, 1) ? 4'hF : 4'h0;
      end
      rst_i = ($urandom_range(0, 299) == 0);
      if (rst_i) dif.iomem_ready_i = 1'b0;
      else if (dif.iomem_valid_o) dif.iomem_ready_i = ($urandom_range(0, 4) == 0);
      else dif.iomem_ready_i = ($urandom_range(0, 7) == 0);
      dif.iomem_rdata_i = $urandom;
    end
    // Let outstanding requests finish with a prompt memory.
    rst_i = 1'b0;
    dif.iomem_ready_i = 1'b0;
    drained = 1'b0;
    for (int c = 0; c < 100 && !drained; c++) begin
      @(negedge clk_i);
      bd = dif.l1b_ready_o; vd = dif.l1v_ready_o;
      @(posedge clk_i);
      #1;
      if (bd) dif.l1b_valid_i = 1'b0;
      if (vd) dif.l1v_valid_i = 1'b0;
      dif.iomem_ready_i = dif.iomem_valid_o;
      drained = !dif.l1b_valid_i && !dif.l1v_valid_i && !dif.iomem_valid_o;
    end
    check("drain_done", 32'(drained), 1);
    repeat (3) @(negedge clk_i);
    #3;
    check("grants_left", bus_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/anabellek_hakem.md
Name: anabellek_hakem

Overview:
- Main-memory arbiter sitting directly downstream of the L1 instruction-cache controller and the L1 data-cache controller.
- Merges their two iomem-style request ports onto the single main-memory iomem bus.
- Grants are round-robin and held until the memory acknowledges.
- A watchdog terminates transactions the memory never answers.

Parameters:
ZAMAN_ASIMI, 1024, cycles a granted transaction may wait for iomem_ready_i before forced termination; 0 disables the watchdog
HATA_VERISI, 32'hDEAD_BEEF, read data returned to the requester on a watchdog termination

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous, active-high reset
l1b_addr_i  input  [18:2]  instruction-cache word address
l1b_valid_i  input  1  instruction-cache read request (read-only port)
l1b_rdata_o  output  32  read data to instruction cache
l1b_ready_o  output  1  one-cycle acknowledge to instruction cache
l1v_addr_i  input  [18:2]  data-cache word address
l1v_valid_i  input  1  data-cache request
l1v_wdata_i  input  32  data-cache write data
l1v_wstrb_i  input  4  data-cache byte strobes; 0 = read, 4'b1111 = write
l1v_rdata_o  output  32  read data to data cache
l1v_ready_o  output  1  one-cycle acknowledge to data cache
iomem_addr_o  output  [18:2]  main-memory word address
iomem_valid_o  output  1  main-memory request
iomem_wdata_o  output  32  main-memory write data
iomem_wstrb_o  output  4  main-memory byte strobes
iomem_rdata_i  input  32  main-memory read data
iomem_ready_i  input  1  main-memory acknowledge
hata_o  output  1  sticky watchdog-timeout flag

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- States: BOSTA (idle), L1B_AKTIF, L1V_AKTIF. Reset -> BOSTA, son_sahip = L1V (so L1B wins the first tie), watchdog counter = 0, hata_o = 0.
- Requester handshake: a requester raises valid with a stable payload and holds it until its ready pulses. Valid still high in the cycle after ready is a new request.
- Arbitration in BOSTA:
  - Only l1b_valid_i -> L1B_AKTIF. Only l1v_valid_i -> L1V_AKTIF.
  - Both -> grant to the port that is not son_sahip. son_sahip is updated to the winner on grant.
  - Neither -> stay in BOSTA.
- Bus outputs in BOSTA: iomem_valid_o = 0, iomem_addr_o / iomem_wdata_o = 0, iomem_wstrb_o = 0.
- Bus outputs in a granted state: combinational mux selected by the state register. iomem_valid_o = 1. addr/wdata/wstrb taken from the granted port. L1B always drives wdata = 0, wstrb = 0.
- Latency: request seen in BOSTA at cycle N -> iomem_valid_o at N+1. Minimum round trip is 2 cycles.
- Completion: in a granted state with iomem_ready_i = 1:
  - The granted port's ready_o = 1 for exactly that cycle (combinational).
  - Next state = BOSTA. One mandatory idle cycle between transactions.
  - The non-granted ready_o stays 0.
- rdata: both l1b_rdata_o and l1v_rdata_o are driven with iomem_rdata_i at all times, except during a watchdog termination (see below).
- iomem_ready_i in BOSTA is ignored.
- Watchdog (ZAMAN_ASIMI > 0):
  - Counter clears on entering a granted state and increments each granted cycle without ready.
  - When the counter reaches ZAMAN_ASIMI-1 with iomem_ready_i still 0:
    - Force completion that cycle: the granted ready_o = 1 and its rdata_o = HATA_VERISI.
    - hata_o is set and stays set until reset.
    - iomem_valid_o drops the next cycle (BOSTA).
  - ready on the deadline cycle itself is a normal completion and does not set hata_o.
- Requester drops valid while granted: protocol violation. The grant is held anyway until ready or timeout.
- Reset mid-transaction: state -> BOSTA next edge, iomem_valid_o = 0, the in-flight transaction is abandoned, no ready is issued.
- All outputs are defined in every state. There are no latches.

Test Plan:
- L1B alone reads 0x00040, memory answers after 3 cycles with 0x1234_5678 -> iomem_valid_o high 3 cycles, l1b_ready_o one pulse with rdata 0x1234_5678, l1v_ready_o stays 0.
- Both valid in the same cycle after reset -> L1B granted first; after its ready and one idle cycle, L1V granted. The next tie goes back to L1B.
- L1V write-back addr 0x1FF00, wdata 0xCAFE_F00D, wstrb 4'b1111, then valid kept high with a new read address -> iomem sees the write, ready, 1 idle cycle, then the read with wstrb 0.
- ZAMAN_ASIMI=8, memory never ready -> after 8 granted cycles l1v_ready_o pulses with rdata 0xDEAD_BEEF, hata_o = 1 and stays 1 through later normal transfers.
- rst_i asserted for 1 cycle mid-grant -> iomem_valid_o = 0 next cycle, no ready pulse, hata_o = 0, next tie granted to L1B.
- iomem_ready_i pulsed while in BOSTA -> no ready_o on either port, state unchanged.
